// File: rtl/paddle_motion_ctrl.sv
// Paddle input conditioning and per-frame motion: button sync/debounce, vsync
// edge detect, and a clamped, accelerating horizontal position for the renderer.
module paddle_motion_ctrl #(
   parameter int unsigned INIT_X          = 200,
   parameter int unsigned RECT_WIDTH      = 240,
   parameter int unsigned SCREEN_WIDTH    = 640,
   parameter int unsigned MAX_SPEED       = 4,
   parameter int unsigned ACCEL_FRAMES    = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       btn_right,
   input  logic       btn_left,
   output logic [9:0] rect_x,
   output logic       frame_tick,
   output logic       moving,
   output logic       at_edge
);

   localparam int unsigned MAX_X = SCREEN_WIDTH - RECT_WIDTH;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned POS_W = 11;
   localparam int unsigned X_W   = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE_R = 2'd1,
      MOVE_L = 2'd2
   } state_t;

   logic [1:0]            r_sync_r;
   logic [1:0]            r_sync_l;
   logic [1:0]            w_samp;
   logic [1:0]            r_deb;
   logic [1:0][CNT_W-1:0] r_cnt;
   logic                  r_vsync_q;
   logic                  r_frame_tick;

   state_t                r_state;
   state_t                w_state_nx;
   state_t                w_tgt;
   logic [3:0]            r_speed;
   logic [3:0]            r_hold;
   logic [3:0]            w_speed_nx;
   logic [3:0]            w_hold_nx;
   logic [3:0]            w_spd;
   logic [3:0]            w_hld;
   logic [3:0]            w_hold_inc;
   logic [X_W-1:0]        r_x;
   logic [X_W-1:0]        w_x_nx;
   logic [POS_W-1:0]      w_sum;
   logic                  w_dir_r;
   logic                  w_dir_l;
   logic                  w_at_limit;

   // Two-flop synchronisers for the raw buttons
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_r <= '0;
         r_sync_l <= '0;
      end else begin
         r_sync_r <= {r_sync_r[0], btn_right};
         r_sync_l <= {r_sync_l[0], btn_left};
      end
   end

   assign w_samp = {r_sync_l[1], r_sync_r[1]};

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         r_deb <= '0;
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_samp[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_deb[i] <= w_samp[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // vsync_q resets high so a vsync already high at release is not an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vsync_q    <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_vsync_q    <= vsync;
         r_frame_tick <= vsync & ~r_vsync_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_speed <= '0;
         r_hold  <= '0;
         r_x     <= X_W'(INIT_X);
      end else begin
         r_state <= w_state_nx;
         r_speed <= w_speed_nx;
         r_hold  <= w_hold_nx;
         r_x     <= w_x_nx;
      end
   end

   assign w_dir_r = r_deb[0] & ~r_deb[1];
   assign w_dir_l = r_deb[1] & ~r_deb[0];

   always_comb begin
      w_state_nx = r_state;
      w_speed_nx = r_speed;
      w_hold_nx  = r_hold;
      w_x_nx     = r_x;
      w_tgt      = w_dir_r ? MOVE_R : MOVE_L;
      w_spd      = 4'd1;
      w_hld      = 4'd0;
      w_hold_inc = r_hold + 4'd1;
      w_sum      = '0;
      w_at_limit = w_dir_r ? (r_x == X_W'(MAX_X)) : (r_x == '0);
      if (r_frame_tick) begin
         if (!w_dir_r && !w_dir_l) begin
            w_state_nx = IDLE;
            w_speed_nx = '0;
            w_hold_nx  = '0;
         end else begin
            if (r_state == w_tgt) begin
               if (w_hold_inc == 4'(ACCEL_FRAMES)) begin
                  w_hld = 4'd0;
                  w_spd = (r_speed >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : r_speed + 4'd1;
               end else begin
                  w_hld = w_hold_inc;
                  w_spd = r_speed;
               end
            end
            w_state_nx = w_tgt;
            w_sum      = {1'b0, r_x} + POS_W'(w_spd);
            // Pinned against a limit: hold position and restart the ramp
            if (w_at_limit) begin
               w_speed_nx = 4'd1;
               w_hold_nx  = 4'd0;
            end else begin
               w_speed_nx = w_spd;
               w_hold_nx  = w_hld;
               if (w_dir_r) begin
                  w_x_nx = (w_sum > POS_W'(MAX_X)) ? X_W'(MAX_X) : w_sum[X_W-1:0];
               end else begin
                  w_x_nx = (POS_W'(w_spd) > {1'b0, r_x}) ? '0 : r_x - X_W'(w_spd);
               end
            end
         end
      end
   end

   assign rect_x     = r_x;
   assign frame_tick = r_frame_tick;
   assign moving     = (r_state != IDLE);
   assign at_edge    = (r_x == '0) || (r_x == X_W'(MAX_X));

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Bench for paddle_motion_ctrl: signed-arithmetic frame model checked every cycle,
// plus hand-computed positions along a directed button/vsync script.
module tb_paddle_motion_ctrl;

   localparam int DEB   = 16;
   localparam int MAXX  = 400;
   localparam int MAXS  = 4;
   localparam int ACCEL = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       vsync;
   logic       btn_right;
   logic       btn_left;
   logic [9:0] rect_x;
   logic       frame_tick;
   logic       moving;
   logic       at_edge;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int m_x, m_dir, m_speed, m_hold, m_tick, m_vsq;
   int m_hr [2];
   int m_hl [2];
   int m_deb_r, m_deb_l, m_run_r, m_run_l;

   paddle_motion_ctrl #(
      .INIT_X(200), .RECT_WIDTH(240), .SCREEN_WIDTH(640),
      .MAX_SPEED(MAXS), .ACCEL_FRAMES(ACCEL), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .reset(reset), .vsync(vsync),
      .btn_right(btn_right), .btn_left(btn_left),
      .rect_x(rect_x), .frame_tick(frame_tick),
      .moving(moving), .at_edge(at_edge)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One frame's worth of motion, in signed pixel arithmetic
   task automatic motion(input int d);
      int ns, nh;
      if (d == 0) begin
         m_dir = 0; m_speed = 0; m_hold = 0;
      end else begin
         if (d != m_dir) begin
            ns = 1; nh = 0;
         end else begin
            nh = m_hold + 1;
            ns = m_speed;
            if (nh == ACCEL) begin
               nh = 0;
               ns = (m_speed + 1 > MAXS) ? MAXS : m_speed + 1;
            end
         end
         m_dir = d;
         if ((d > 0 && m_x == MAXX) || (d < 0 && m_x == 0)) begin
            m_speed = 1; m_hold = 0;
         end else begin
            m_speed = ns; m_hold = nh;
            m_x = m_x + d * ns;
            if (m_x > MAXX) m_x = MAXX;
            if (m_x < 0) m_x = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_x = 200; m_dir = 0; m_speed = 0; m_hold = 0;
         m_tick = 0; m_vsq = 1;
         m_hr[0] = 0; m_hr[1] = 0; m_hl[0] = 0; m_hl[1] = 0;
         m_deb_r = 0; m_deb_l = 0; m_run_r = 0; m_run_l = 0;
      end else begin
         if (m_tick != 0) motion(m_deb_r - m_deb_l);
         m_tick = (vsync && m_vsq == 0) ? 1 : 0;
         m_vsq  = vsync ? 1 : 0;
         if (m_hr[1] != m_deb_r) begin
            m_run_r++;
            if (m_run_r == DEB) begin m_deb_r = m_hr[1]; m_run_r = 0; end
         end else m_run_r = 0;
         if (m_hl[1] != m_deb_l) begin
            m_run_l++;
            if (m_run_l == DEB) begin m_deb_l = m_hl[1]; m_run_l = 0; end
         end else m_run_l = 0;
         m_hr[1] = m_hr[0]; m_hr[0] = btn_right ? 1 : 0;
         m_hl[1] = m_hl[0]; m_hl[0] = btn_left ? 1 : 0;
      end
   end

   always @(posedge clk) begin
      #1;
      check("rect_x", int'(rect_x), m_x);
      check("frame_tick", int'(frame_tick), m_tick);
      check("moving", int'(moving), (m_dir != 0) ? 1 : 0);
      check("at_edge", int'(at_edge), (m_x == 0 || m_x == MAXX) ? 1 : 0);
      check("x_in_range", (int'(rect_x) <= MAXX) ? 1 : 0, 1);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      @(negedge clk);
      vsync = 1'b1;
      cycles(3);
      vsync = 1'b0;
      cycles(30);
   endtask

   initial begin
      int n;
      reset = 1'b1; vsync = 1'b1; btn_right = 1'b0; btn_left = 1'b0;
      cycles(3);
      reset = 1'b0;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (frame_tick) n++;
      end
      check("no_tick_after_reset", n, 0);
      check("reset_x", int'(rect_x), 200);
      check("reset_moving", int'(moving), 0);
      vsync = 1'b0;
      cycles(5);

      // hold right: unit steps for 8 frames, then speed 2
      btn_right = 1'b1;
      cycles(25);
      for (int k = 1; k <= 9; k++) begin
         frame();
         check("hold_right_x", int'(rect_x), (k <= 8) ? 200 + k : 210);
         check("hold_right_moving", int'(moving), 1);
      end

      // both pressed cancels motion
      btn_left = 1'b1;
      cycles(25);
      repeat (3) frame();
      check("both_x", int'(rect_x), 210);
      check("both_moving", int'(moving), 0);

      // short left glitch is ignored
      btn_left = 1'b0; btn_right = 1'b0;
      cycles(25);
      btn_left = 1'b1;
      cycles(10);
      btn_left = 1'b0;
      cycles(25);
      frame();
      check("glitch_x", int'(rect_x), 210);
      check("glitch_moving", int'(moving), 0);

      // ramp right to full speed and into the right limit
      btn_right = 1'b1;
      cycles(25);
      repeat (25) frame();
      check("speed4_x25", int'(rect_x), 262);
      frame();
      check("speed4_x26", int'(rect_x), 266);
      repeat (40) frame();
      check("sat_x", int'(rect_x), 400);
      check("sat_edge", int'(at_edge), 1);

      // reverse: speed restarts at 1
      btn_right = 1'b0; btn_left = 1'b1;
      cycles(25);
      frame();
      check("rev_x", int'(rect_x), 399);
      frame();
      check("rev_x2", int'(rect_x), 398);
      btn_left = 1'b0;
      cycles(25);
      frame();
      check("pause_x", int'(rect_x), 398);
      check("pause_moving", int'(moving), 0);

      // run left at full speed down to x=2, then clamp at 0
      btn_left = 1'b1;
      cycles(25);
      repeat (24) frame();
      check("left_x24", int'(rect_x), 350);
      repeat (87) frame();
      check("left_x2", int'(rect_x), 2);
      frame();
      check("left_clamp_x", int'(rect_x), 0);
      check("left_clamp_edge", int'(at_edge), 1);
      frame();
      check("left_hold_x", int'(rect_x), 0);

      // reset landing on a frame_tick cycle applies no move
      btn_left = 1'b0; btn_right = 1'b1;
      cycles(25);
      repeat (3) frame();
      check("pre_reset_x", int'(rect_x), 3);
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vsync = 1'b0;
      check("mid_reset_x", int'(rect_x), 200);
      check("mid_reset_moving", int'(moving), 0);
      check("mid_reset_tick", int'(frame_tick), 0);
      cycles(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
